// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single-port data memory between the CPU data port (m0) and a
//   secondary master (m1, DMA / debug loader). m0 wins conflicts unless m1
//   has waited MAX_WAIT-1 consecutive denied cycles. m1 may hold the port
//   across a burst with m1_lock. Also counts m0 stall cycles.
//
//   Handshake: a master raises mx_req with we/addr/din/be stable and holds
//   them until mx_gnt=1. mx_gnt is combinational and means the access is
//   performed in this cycle (read data on mx_dout now, write committed at the
//   closing posedge). At most one gnt is high per cycle.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   m0_* / m1_*               master request, we, word addr, wdata, byte enables
//   m1_lock                   m1 keeps ownership after the current grant
//   m0_gnt / m1_gnt           access performed this cycle
//   m0_dout / m1_dout         read data (valid with the matching gnt)
//   mem_addr/din/be/wren      memory port, mem_dout async read data
//   stall_cnt                 saturating count of m0 denied cycles
//   dbg_locked                1 while m1 holds the lock (arbiter mode)
module dmem_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [11:2] m0_addr,
    input  logic [31:0] m0_din,
    input  logic [3:0]  m0_be,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [11:2] m1_addr,
    input  logic [31:0] m1_din,
    input  logic [3:0]  m1_be,
    input  logic        m1_lock,
    output logic        m0_gnt,
    output logic        m1_gnt,
    output logic [31:0] m0_dout,
    output logic [31:0] m1_dout,
    output logic [11:2] mem_addr,
    output logic [31:0] mem_din,
    output logic [3:0]  mem_be,
    output logic        mem_wren,
    input  logic [31:0] mem_dout,
    output logic [15:0] stall_cnt,
    output logic        dbg_locked
);

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    typedef enum logic {
        NORMAL = 1'b0,
        LOCKED = 1'b1
    } mode_t;

    mode_t       mode_q, mode_d;
    logic [7:0]  wcnt_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= NORMAL;
        end else begin
            mode_q <= mode_d;
        end
    end

    // Grant decision and next mode
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        mode_d = mode_q;
        if (!rst) begin
            if (mode_q == LOCKED) begin
                m1_gnt = m1_req;
            end else if (m0_req && m1_req) begin
                // m1 has waited long enough: force one grant its way
                if (wcnt_q == WAIT_LAST) begin
                    m1_gnt = 1'b1;
                end else begin
                    m0_gnt = 1'b1;
                end
            end else begin
                m0_gnt = m0_req;
                m1_gnt = m1_req;
            end
        end
        case (mode_q)
            NORMAL: if (m1_gnt && m1_lock) mode_d = LOCKED;
            // Dropping req releases the lock even if m1_lock is still high
            LOCKED: if (!m1_req || (m1_gnt && !m1_lock)) mode_d = NORMAL;
            default: mode_d = NORMAL;
        endcase
    end

    // m1 consecutive-denial counter
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q <= 8'd0;
        end else if (!m1_req || m1_gnt) begin
            wcnt_q <= 8'd0;
        end else if (wcnt_q != WAIT_LAST) begin
            wcnt_q <= wcnt_q + 8'd1;
        end
    end

    // m0 stall counter, saturating
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 16'd0;
        end else if (m0_req && !m0_gnt && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    // Memory port mux; reads never present byte enables to the memory
    always_comb begin
        mem_addr = m0_addr;
        mem_din  = 32'd0;
        mem_be   = 4'd0;
        mem_wren = 1'b0;
        if (m0_gnt) begin
            mem_din  = m0_din;
            mem_wren = m0_we;
            mem_be   = m0_we ? m0_be : 4'd0;
        end else if (m1_gnt) begin
            mem_addr = m1_addr;
            mem_din  = m1_din;
            mem_wren = m1_we;
            mem_be   = m1_we ? m1_be : 4'd0;
        end
    end

    assign m0_dout    = mem_dout;
    assign m1_dout    = mem_dout;
    assign dbg_locked = (mode_q == LOCKED);

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  localparam int W = 65;

  // observation vector: {mem_addr, m0_gnt, m1_gnt, mem_wren, mem_be, stall_cnt, rdata}
  localparam logic [W-1:0] M_ADDR = {10'h3FF, 55'd0};
  localparam logic [W-1:0] M_CTL  = {10'd0, 1'b1, 1'b1, 1'b1, 4'hF, 48'd0};
  localparam logic [W-1:0] M_ST   = {10'd0, 7'd0, 16'hFFFF, 32'd0};
  localparam logic [W-1:0] M_DO   = {33'd0, 32'hFFFF_FFFF};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [11:2] m0_addr, m1_addr;
  logic [31:0] m0_din, m1_din;
  logic [3:0]  m0_be, m1_be;
  logic        m0_gnt, m1_gnt, dbg_locked;
  logic [31:0] m0_dout, m1_dout, mem_din, mem_dout;
  logic [11:2] mem_addr;
  logic [3:0]  mem_be;
  logic        mem_wren;
  logic [15:0] stall_cnt;

  logic        w1_m0_gnt, w1_m1_gnt, w1_locked, w1_mem_wren;
  logic [31:0] w1_m0_dout, w1_m1_dout, w1_mem_din, w1_mem_dout;
  logic [11:2] w1_mem_addr;
  logic [3:0]  w1_mem_be;
  logic [15:0] w1_stall_cnt;

  dmem_arbiter #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_din(m0_din), .m0_be(m0_be),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_din(m1_din), .m1_be(m1_be),
    .m1_lock(m1_lock), .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_dout(m0_dout), .m1_dout(m1_dout),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_be(mem_be), .mem_wren(mem_wren),
    .mem_dout(mem_dout), .stall_cnt(stall_cnt), .dbg_locked(dbg_locked)
  );

  // MAX_WAIT=1 instance: m1 must win every conflict
  dmem_arbiter #(.MAX_WAIT(1)) dut_w1 (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_din(m0_din), .m0_be(m0_be),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_din(m1_din), .m1_be(m1_be),
    .m1_lock(m1_lock), .m0_gnt(w1_m0_gnt), .m1_gnt(w1_m1_gnt), .m0_dout(w1_m0_dout),
    .m1_dout(w1_m1_dout), .mem_addr(w1_mem_addr), .mem_din(w1_mem_din), .mem_be(w1_mem_be),
    .mem_wren(w1_mem_wren), .mem_dout(w1_mem_dout), .stall_cnt(w1_stall_cnt),
    .dbg_locked(w1_locked)
  );

  // ---------------- memory model (async read, posedge write) ----------------
  logic [31:0] mem [0:1023];
  assign mem_dout    = mem[mem_addr];
  assign w1_mem_dout = mem[w1_mem_addr];

  always @(posedge clk) begin
    if (mem_wren) begin
      case (mem_be)
        4'b1111: mem[mem_addr]        <= mem_din;
        4'b0011: mem[mem_addr][15:0]  <= mem_din[15:0];
        4'b1100: mem[mem_addr][31:16] <= mem_din[15:0];
        4'b0001: mem[mem_addr][7:0]   <= mem_din[7:0];
        4'b0010: mem[mem_addr][15:8]  <= mem_din[7:0];
        4'b0100: mem[mem_addr][23:16] <= mem_din[7:0];
        4'b1000: mem[mem_addr][31:24] <= mem_din[7:0];
        default: ;
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mask_q[$];
  string        tag_q[$];

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mkv(input logic [9:0] a, input logic g0, input logic g1,
                                       input logic wr, input logic [3:0] be,
                                       input logic [15:0] st, input logic [31:0] d);
    return {a, g0, g1, wr, be, st, d};
  endfunction

  function automatic logic [W-1:0] obs_vec();
    return {mem_addr, m0_gnt, m1_gnt, mem_wren, mem_be, stall_cnt,
            (m1_gnt ? m1_dout : m0_dout)};
  endfunction

  task automatic push_exp(input string tag, input logic [W-1:0] e, input logic [W-1:0] m);
    exp_q.push_back(e);
    mask_q.push_back(m);
    tag_q.push_back(tag);
  endtask

  task automatic sample();
    logic [W-1:0] e, m;
    string t;
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      m = mask_q.pop_front();
      t = tag_q.pop_front();
      check_eq(t, obs_vec() & m, e & m);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  // ---------------- drivers ----------------
  task automatic drive_m0(input logic req, input logic we, input logic [9:0] addr,
                          input logic [31:0] din, input logic [3:0] be);
    m0_req = req; m0_we = we; m0_addr = addr; m0_din = din; m0_be = be;
  endtask

  task automatic drive_m1(input logic req, input logic we, input logic [9:0] addr,
                          input logic [31:0] din, input logic [3:0] be, input logic lock);
    m1_req = req; m1_we = we; m1_addr = addr; m1_din = din; m1_be = be; m1_lock = lock;
  endtask

  // ---------------- stimulus ----------------
  logic [3:0] be_tab [7];
  int m1_wait;

  initial begin
    be_tab = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8};

    // reset with both masters requesting writes
    rst = 1'b1;
    drive_m0(1'b1, 1'b1, 10'h3AA, 32'h5, 4'hF);
    drive_m1(1'b1, 1'b1, 10'h3AB, 32'h6, 4'hF, 1'b1);
    push_exp("rst_out", mkv(10'd0, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0, 32'd0), M_CTL);
    step();
    push_exp("rst_state", mkv(10'd0, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0, 32'd0), M_CTL | M_ST);
    step();
    rst = 1'b0;

    // m0-only write then read
    drive_m1(1'b0, 1'b0, 10'h0, 32'h0, 4'h0, 1'b0);
    drive_m0(1'b1, 1'b1, 10'h010, 32'hDEADBEEF, 4'hF);
    push_exp("m0_sw", mkv(10'h010, 1'b1, 1'b0, 1'b1, 4'hF, 16'd0, 32'd0), M_ADDR | M_CTL | M_ST);
    step();
    drive_m0(1'b1, 1'b0, 10'h010, 32'h0, 4'hF);
    push_exp("m0_lw", mkv(10'h010, 1'b1, 1'b0, 1'b0, 4'h0, 16'd0, 32'hDEADBEEF),
             M_ADDR | M_CTL | M_ST | M_DO);
    step();
    drive_m0(1'b1, 1'b1, 10'h020, 32'h11223344, 4'hF);
    push_exp("m0_sw2", mkv(10'h020, 1'b1, 1'b0, 1'b1, 4'hF, 16'd0, 32'd0), M_ADDR | M_CTL);
    step();

    // continuous conflict, no lock
    drive_m0(1'b1, 1'b0, 10'h010, 32'h0, 4'hF);
    drive_m1(1'b1, 1'b0, 10'h020, 32'h0, 4'hF, 1'b0);
    for (int i = 0; i < 8; i++) begin
      logic g1;
      g1 = (i == 3) || (i == 7);
      push_exp($sformatf("conflict_c%0d", i),
               mkv(g1 ? 10'h020 : 10'h010, ~g1, g1, 1'b0, 4'h0, (i > 3) ? 16'd1 : 16'd0,
                   g1 ? 32'h11223344 : 32'hDEADBEEF),
               M_ADDR | M_CTL | M_ST | M_DO);
      sample();
      check_eq($sformatf("w1_m1_wins_c%0d", i), W'({w1_m0_gnt, w1_m1_gnt}), W'(2'b01));
      advance();
    end
    drive_m0(1'b0, 1'b0, 10'h010, 32'h0, 4'h0);
    drive_m1(1'b0, 1'b0, 10'h020, 32'h0, 4'h0, 1'b0);
    push_exp("conflict_stall", mkv(10'd0, 1'b0, 1'b0, 1'b0, 4'd0, 16'd2, 32'd0), M_CTL | M_ST);
    step();

    // lock burst
    drive_m1(1'b1, 1'b0, 10'h020, 32'h0, 4'hF, 1'b1);
    push_exp("lock_c0", mkv(10'h020, 1'b0, 1'b1, 1'b0, 4'h0, 16'd2, 32'h11223344),
             M_ADDR | M_CTL | M_ST | M_DO);
    step();
    drive_m0(1'b1, 1'b0, 10'h010, 32'h0, 4'hF);
    push_exp("lock_c1", mkv(10'h020, 1'b0, 1'b1, 1'b0, 4'h0, 16'd2, 32'h11223344),
             M_ADDR | M_CTL | M_ST | M_DO);
    step();
    push_exp("lock_c2", mkv(10'h020, 1'b0, 1'b1, 1'b0, 4'h0, 16'd3, 32'd0), M_CTL | M_ST);
    step();
    drive_m1(1'b1, 1'b0, 10'h020, 32'h0, 4'hF, 1'b0);
    push_exp("lock_c3", mkv(10'h020, 1'b0, 1'b1, 1'b0, 4'h0, 16'd4, 32'd0), M_CTL | M_ST);
    step();
    drive_m1(1'b0, 1'b0, 10'h020, 32'h0, 4'h0, 1'b0);
    push_exp("lock_c4", mkv(10'h010, 1'b1, 1'b0, 1'b0, 4'h0, 16'd5, 32'hDEADBEEF),
             M_ADDR | M_CTL | M_ST | M_DO);
    step();

    // m1 store-byte into lane 2, then read back
    drive_m0(1'b0, 1'b0, 10'h010, 32'h0, 4'h0);
    drive_m1(1'b1, 1'b1, 10'h020, 32'h000000AB, 4'b0100, 1'b0);
    push_exp("m1_sb", mkv(10'h020, 1'b0, 1'b1, 1'b1, 4'b0100, 16'd5, 32'd0), M_ADDR | M_CTL | M_ST);
    step();
    drive_m1(1'b1, 1'b0, 10'h020, 32'h0, 4'hF, 1'b0);
    push_exp("m1_sb_rd", mkv(10'h020, 1'b0, 1'b1, 1'b0, 4'h0, 16'd5, 32'h11AB3344),
             M_ADDR | M_CTL | M_DO);
    step();

    // reset while locked with both requesting
    drive_m1(1'b1, 1'b1, 10'h030, 32'hCAFEF00D, 4'hF, 1'b1);
    push_exp("rl_c0", mkv(10'h030, 1'b0, 1'b1, 1'b1, 4'hF, 16'd5, 32'd0), M_ADDR | M_CTL);
    step();
    drive_m0(1'b1, 1'b0, 10'h010, 32'h0, 4'hF);
    push_exp("rl_c1", mkv(10'h030, 1'b0, 1'b1, 1'b1, 4'hF, 16'd5, 32'd0), M_ADDR | M_CTL | M_ST);
    step();
    rst = 1'b1;
    push_exp("rl_rst", mkv(10'd0, 1'b0, 1'b0, 1'b0, 4'h0, 16'd0, 32'd0), M_CTL);
    step();
    rst = 1'b0;
    push_exp("rl_after", mkv(10'h010, 1'b1, 1'b0, 1'b0, 4'h0, 16'd0, 32'hDEADBEEF),
             M_ADDR | M_CTL | M_ST | M_DO);
    step();

    // idle
    drive_m0(1'b0, 1'b0, 10'h155, 32'h1234, 4'hF);
    drive_m1(1'b0, 1'b1, 10'h2AA, 32'h99, 4'hF, 1'b0);
    for (int i = 0; i < 2; i++) begin
      push_exp($sformatf("idle_c%0d", i), mkv(10'h155, 1'b0, 1'b0, 1'b0, 4'h0, 16'd0, 32'd0),
               M_ADDR | M_CTL | M_ST);
      sample();
      check_eq("idle_din", W'(mem_din), '0);
      advance();
    end

    // random traffic without lock
    m1_wait = 0;
    for (int i = 0; i < 300; i++) begin
      drive_m0(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               10'($urandom_range(16'h40, 16'h43)), $urandom, be_tab[$urandom_range(0, 6)]);
      drive_m1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               10'($urandom_range(16'h40, 16'h43)), $urandom, be_tab[$urandom_range(0, 6)], 1'b0);
      sample();
      check_eq("rnd_excl", W'(m0_gnt & m1_gnt), '0);
      check_eq("rnd_busy", W'(m0_gnt | m1_gnt), W'(m0_req | m1_req));
      if (m1_req && !m0_req) check_eq("rnd_m1_alone", W'(m1_gnt), W'(1'b1));
      if (m0_gnt) begin
        check_eq("rnd_m0_addr", W'(mem_addr), W'(m0_addr));
        check_eq("rnd_m0_wren", W'(mem_wren), W'(m0_we));
        if (!m0_we) check_eq("rnd_m0_rd", W'(m0_dout), W'(mem[m0_addr]));
      end
      if (m1_gnt) begin
        check_eq("rnd_m1_addr", W'(mem_addr), W'(m1_addr));
        check_eq("rnd_m1_wren", W'(mem_wren), W'(m1_we));
        if (!m1_we) check_eq("rnd_m1_rd", W'(m1_dout), W'(mem[m1_addr]));
      end
      if (m1_req && !m1_gnt) m1_wait++;
      else m1_wait = 0;
      check_eq("rnd_starve", W'(m1_wait > 3), '0);
      advance();
    end

    if (exp_q.size() != 0) check_eq("queue_empty", W'(exp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
